// File: rtl/pipe_mon_pkg.sv
// Shared encodings for the pipeline monitor: FSM states, counter selects
// and the canonical NOP used for bubble detection.
package pipe_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } state_e;

  localparam int          NUM_CNT    = 8;
  localparam logic [2:0]  SEL_CYCLES = 3'd0;
  localparam logic [2:0]  SEL_RETIRE = 3'd1;
  localparam logic [2:0]  SEL_STALL  = 3'd2;
  localparam logic [2:0]  SEL_FLUSH  = 3'd3;
  localparam logic [2:0]  SEL_FWDA   = 3'd4;
  localparam logic [2:0]  SEL_FWDB   = 3'd5;
  localparam logic [2:0]  SEL_FWDANY = 3'd6;
  localparam logic [2:0]  SEL_BUBBLE = 3'd7;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  // An all-zero word or the addi x0,x0,0 NOP both count as a bubble.
  function automatic logic is_bubble(input logic [31:0] instr);
    return (instr == 32'h0000_0000) || (instr == NOP_INSTR);
  endfunction

endpackage

// File: rtl/pipe_monitor_if.sv
// Push/pop handshake between the monitor core and its retire-trace FIFO.
interface pipe_monitor_if #(
  parameter int W  = 64,
  parameter int LW = 5
);
  logic          push;
  logic [W-1:0]  push_data;
  logic          pop;
  logic          clear;
  logic          head_valid;
  logic [W-1:0]  head_data;
  logic [LW-1:0] level;
  logic          ovf;

  modport master (
    output push, push_data, pop, clear,
    input  head_valid, head_data, level, ovf
  );

  modport slave (
    input  push, push_data, pop, clear,
    output head_valid, head_data, level, ovf
  );
endinterface

// File: rtl/pipe_monitor_trace_fifo.sv
// Retire-trace FIFO with a registered head; when full, either refuses the
// new entry or drops the oldest one, flagging the loss in a sticky bit.
module trace_fifo #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 16,
  parameter int OVERWRITE = 0
) (
  input  logic           clk,
  input  logic           reset_n,
  pipe_monitor_if.slave  fif
);
  localparam int            AW       = $clog2(DEPTH);
  localparam int            LW       = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_ovf, r_head_valid;
  logic [WIDTH-1:0] r_head_data;

  logic             w_full, w_pop, w_lost, w_wr_en, w_rd_adv;
  logic [AW-1:0]    w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [LW-1:0]    w_level_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  // Next pointers/level; the head is pre-computed so it can be registered.
  always_comb begin
    w_full       = (r_level == LVL_FULL);
    w_pop        = fif.pop && r_head_valid;
    w_lost       = fif.push && w_full && !w_pop;
    w_wr_en      = fif.push && (!w_full || w_pop || (OVERWRITE != 0));
    w_rd_adv     = w_pop || (w_lost && (OVERWRITE != 0));
    w_wr_ptr_nxt = w_wr_en  ? (r_wr_ptr + AW'(1)) : r_wr_ptr;
    w_rd_ptr_nxt = w_rd_adv ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
    w_level_nxt  = r_level + LW'(w_wr_en) - LW'(w_rd_adv);
    if (w_level_nxt == '0) begin
      w_head_nxt = '0;
    end else if (w_wr_en && (r_wr_ptr == w_rd_ptr_nxt)) begin
      w_head_nxt = fif.push_data;
    end else begin
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  // Storage array; contents are don't-care until covered by the level.
  always_ff @(posedge clk) begin
    if (w_wr_en && !fif.clear) begin
      r_mem[r_wr_ptr] <= fif.push_data;
    end
  end

  // Pointers, level, sticky overflow and registered head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_ovf        <= 1'b0;
      r_head_valid <= 1'b0;
      r_head_data  <= '0;
    end else if (fif.clear) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_ovf        <= 1'b0;
      r_head_valid <= 1'b0;
      r_head_data  <= '0;
    end else begin
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_level      <= w_level_nxt;
      r_ovf        <= r_ovf || w_lost;
      r_head_valid <= (w_level_nxt != '0);
      r_head_data  <= w_head_nxt;
    end
  end

  assign fif.head_valid = r_head_valid;
  assign fif.head_data  = r_head_data;
  assign fif.level      = r_level;
  assign fif.ovf        = r_ovf;

endmodule

// File: rtl/pipe_monitor.sv
// Pipeline performance monitor: saturating event counters, PC trigger FSM
// and a retire trace buffered in trace_fifo.
module pipe_monitor
  import pipe_mon_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int TRACE_DEPTH = 16,
  parameter int OVERWRITE   = 0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_enable,
  input  logic                         i_clear,
  input  logic                         i_trig_en,
  input  logic [31:0]                  i_trig_pc,
  input  logic                         i_retire_valid,
  input  logic [31:0]                  i_retire_pc,
  input  logic [31:0]                  i_retire_instr,
  input  logic                         i_stall,
  input  logic                         i_flush,
  input  logic [1:0]                   i_forwardA,
  input  logic [1:0]                   i_forwardB,
  input  logic [2:0]                   i_cnt_sel,
  output logic [CNT_W-1:0]             o_cnt_value,
  output logic                         o_trace_valid,
  input  logic                         i_trace_ready,
  output logic [31:0]                  o_trace_pc,
  output logic [31:0]                  o_trace_instr,
  output logic [$clog2(TRACE_DEPTH):0] o_trace_level,
  output logic                         o_trace_ovf,
  output logic [1:0]                   o_state
);
  localparam int LVL_W = $clog2(TRACE_DEPTH) + 1;

  state_e             r_state, w_state_nxt;
  logic               w_run, w_trig_hit;
  logic [NUM_CNT-1:0] w_inc;
  logic [CNT_W-1:0]   r_cnt [NUM_CNT];
  logic [CNT_W-1:0]   r_cnt_value;

  pipe_monitor_if #(.W(64), .LW(LVL_W)) u_trace_if ();

  // FSM next state and the run qualifier; clear overrides every transition.
  always_comb begin
    w_trig_hit  = i_trig_en && i_retire_valid && (i_retire_pc == i_trig_pc);
    w_run       = (r_state == ST_RUN) && !i_clear;
    w_state_nxt = r_state;
    if (i_clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   w_state_nxt = i_enable ? ST_RUN : ST_IDLE;
        ST_RUN: begin
          if (!i_enable) begin
            w_state_nxt = ST_IDLE;
          end else if (w_trig_hit) begin
            w_state_nxt = ST_FROZEN;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_FROZEN: w_state_nxt = i_enable ? ST_FROZEN : ST_IDLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Per-counter event strobes for this cycle.
  always_comb begin
    w_inc             = '0;
    w_inc[SEL_CYCLES] = 1'b1;
    w_inc[SEL_RETIRE] = i_retire_valid;
    w_inc[SEL_STALL]  = i_stall;
    w_inc[SEL_FLUSH]  = i_flush;
    w_inc[SEL_FWDA]   = (i_forwardA != 2'd0);
    w_inc[SEL_FWDB]   = (i_forwardB != 2'd0);
    w_inc[SEL_FWDANY] = (i_forwardA != 2'd0) || (i_forwardB != 2'd0);
    w_inc[SEL_BUBBLE] = i_retire_valid && is_bubble(i_retire_instr);
  end

  // Saturating event counters, active only while running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CNT; i++) r_cnt[i] <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < NUM_CNT; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (w_run && w_inc[i] && (r_cnt[i] != '1)) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Registered counter readout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt_value <= '0;
    end else begin
      r_cnt_value <= i_clear ? '0 : r_cnt[i_cnt_sel];
    end
  end

  assign u_trace_if.push      = w_run && i_retire_valid;
  assign u_trace_if.push_data = {i_retire_pc, i_retire_instr};
  assign u_trace_if.pop       = i_trace_ready;
  assign u_trace_if.clear     = i_clear;

  trace_fifo #(
    .WIDTH     (64),
    .DEPTH     (TRACE_DEPTH),
    .OVERWRITE (OVERWRITE)
  ) u_trace_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .fif     (u_trace_if)
  );

  assign o_cnt_value   = r_cnt_value;
  assign o_trace_valid = u_trace_if.head_valid;
  assign o_trace_pc    = u_trace_if.head_data[63:32];
  assign o_trace_instr = u_trace_if.head_data[31:0];
  assign o_trace_level = u_trace_if.level;
  assign o_trace_ovf   = u_trace_if.ovf;
  assign o_state       = r_state;

endmodule

// File: tb/tb_pipe_monitor.sv
// Bench for pipe_monitor: two instances (trace refuse / trace overwrite)
// share stimulus; counters read back through a table plus scoreboard.
module tb_pipe_monitor;
  import pipe_mon_pkg::*;

  localparam int CW   = 8;
  localparam int TD   = 4;
  localparam int LW   = 3;
  localparam int NTBL = 13;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable, trig_en, stall, flush;
  logic [31:0] trig_pc, instr;
  logic [1:0]  fa, fb;
  logic [2:0]  sel;

  pipe_monitor_if #(.W(64), .LW(LW)) mon ();

  logic [CW-1:0] cnt0, cnt1;
  logic [31:0]   pc0, in0, pc1, in1;
  logic          v1, ovf1;
  logic [LW-1:0] lvl1;
  logic [1:0]    st0, st1;

  always #5 clk = ~clk;

  pipe_monitor #(.CNT_W(CW), .TRACE_DEPTH(TD), .OVERWRITE(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .i_enable(enable), .i_clear(mon.clear),
    .i_trig_en(trig_en), .i_trig_pc(trig_pc), .i_retire_valid(mon.push),
    .i_retire_pc(mon.push_data[63:32]), .i_retire_instr(mon.push_data[31:0]),
    .i_stall(stall), .i_flush(flush), .i_forwardA(fa), .i_forwardB(fb),
    .i_cnt_sel(sel), .o_cnt_value(cnt0), .o_trace_valid(mon.head_valid),
    .i_trace_ready(mon.pop), .o_trace_pc(pc0), .o_trace_instr(in0),
    .o_trace_level(mon.level), .o_trace_ovf(mon.ovf), .o_state(st0));

  pipe_monitor #(.CNT_W(CW), .TRACE_DEPTH(TD), .OVERWRITE(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .i_enable(enable), .i_clear(mon.clear),
    .i_trig_en(trig_en), .i_trig_pc(trig_pc), .i_retire_valid(mon.push),
    .i_retire_pc(mon.push_data[63:32]), .i_retire_instr(mon.push_data[31:0]),
    .i_stall(stall), .i_flush(flush), .i_forwardA(fa), .i_forwardB(fb),
    .i_cnt_sel(sel), .o_cnt_value(cnt1), .o_trace_valid(v1),
    .i_trace_ready(mon.pop), .o_trace_pc(pc1), .o_trace_instr(in1),
    .o_trace_level(lvl1), .o_trace_ovf(ovf1), .o_state(st1));

  assign mon.head_data = {pc0, in0};

  typedef struct {
    int            scen;
    logic [2:0]    sel;
    logic [CW-1:0] exp;
  } cvec_t;

  cvec_t         tbl [NTBL];
  logic [CW-1:0] cnt_q [$];
  logic [63:0]   q0 [$];
  logic [63:0]   q1 [$];
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mon.push = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    fa       = 2'd0;
    fb       = 2'd0;
  endtask

  task automatic do_clear();
    mon.clear = 1'b1;
    tick();
    mon.clear = 1'b0;
  endtask

  task automatic read_cnts(input int scen);
    for (int i = 0; i < NTBL; i++) begin
      if (tbl[i].scen == scen) begin
        sel = tbl[i].sel;
        cnt_q.push_back(tbl[i].exp);
        tick();
        check($sformatf("s%0d_cnt%0d_dut0", scen, tbl[i].sel), 64'(cnt0), 64'(cnt_q[0]));
        check($sformatf("s%0d_cnt%0d_dut1", scen, tbl[i].sel), 64'(cnt1), 64'(cnt_q.pop_front()));
      end
    end
  endtask

  initial begin
    tbl[0]  = '{1, SEL_CYCLES, 8'd10};
    tbl[1]  = '{1, SEL_RETIRE, 8'd10};
    tbl[2]  = '{1, SEL_STALL,  8'd3};
    tbl[3]  = '{1, SEL_FLUSH,  8'd2};
    tbl[4]  = '{1, SEL_FWDA,   8'd5};
    tbl[5]  = '{1, SEL_FWDB,   8'd4};
    tbl[6]  = '{1, SEL_FWDANY, 8'd5};
    tbl[7]  = '{1, SEL_BUBBLE, 8'd2};
    tbl[8]  = '{4, SEL_RETIRE, 8'd3};
    tbl[9]  = '{4, SEL_CYCLES, 8'd3};
    tbl[10] = '{5, SEL_STALL,  8'd255};
    tbl[11] = '{5, SEL_CYCLES, 8'd255};
    tbl[12] = '{5, SEL_RETIRE, 8'd0};

    reset_n = 1'b0; enable = 1'b0; trig_en = 1'b0; trig_pc = 32'h0; sel = 3'd0;
    instr = 32'h0; mon.clear = 1'b0; mon.pop = 1'b0; mon.push_data = 64'h0;
    idle_inputs();
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    check("rst_state", 64'(st0), 64'(ST_IDLE));
    check("rst_cnt", 64'(cnt0), 64'h0);
    check("rst_valid", 64'(mon.head_valid), 64'h0);
    check("rst_level", 64'(mon.level), 64'h0);

    // Scenario 1: mixed events over ten RUN cycles.
    enable = 1'b1;
    tick();
    check("s1_run", 64'(st0), 64'(ST_RUN));
    for (int k = 0; k < 10; k++) begin
      instr = (k == 2) ? NOP_INSTR : ((k == 5) ? 32'h0 : 32'h00A0_0093);
      mon.push = 1'b1;
      mon.push_data = {32'h100 + 32'(4 * k), instr};
      stall  = (k < 3);
      flush  = (k == 1) || (k == 6);
      fa     = (k >= 4 && k <= 8) ? 2'd1 : 2'd0;
      fb     = (k >= 4 && k < 8) ? 2'd2 : 2'd0;
      enable = (k != 9);
      tick();
    end
    idle_inputs();
    check("s1_idle", 64'(st0), 64'(ST_IDLE));
    read_cnts(1);
    check("s1_level0", 64'(mon.level), 64'd4);
    check("s1_ovf0", 64'(mon.ovf), 64'd1);
    check("s1_level1", 64'(lvl1), 64'd4);
    check("s1_ovf1", 64'(ovf1), 64'd1);

    // Synchronous clear returns everything to reset values.
    do_clear();
    check("clr_cnt", 64'(cnt0), 64'h0);
    check("clr_level", 64'(mon.level), 64'h0);
    check("clr_ovf", 64'(mon.ovf), 64'h0);
    check("clr_valid", 64'(mon.head_valid), 64'h0);
    check("clr_head", mon.head_data, 64'h0);

    // Scenario 3: clear discards a same-cycle push; push+pop when full.
    enable = 1'b1;
    tick();
    mon.clear = 1'b1; mon.push = 1'b1; mon.push_data = {32'hDEAD_0000, 32'h0};
    tick();
    mon.clear = 1'b0; mon.push = 1'b0;
    check("s3_clr_state", 64'(st0), 64'(ST_IDLE));
    check("s3_clr_level", 64'(mon.level), 64'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      mon.push = 1'b1;
      mon.push_data = {32'h40 + 32'(4 * k), 32'h0000_0033};
      tick();
    end
    mon.push_data = {32'h50, 32'h0000_0033};
    mon.pop = 1'b1; enable = 1'b0;
    tick();
    mon.pop = 1'b0; mon.push = 1'b0;
    check("s3_level0", 64'(mon.level), 64'd4);
    check("s3_ovf0", 64'(mon.ovf), 64'd0);
    check("s3_level1", 64'(lvl1), 64'd4);
    check("s3_ovf1", 64'(ovf1), 64'd0);
    check("s3_head0", 64'(pc0), 64'h44);
    check("s3_head1", 64'(pc1), 64'h44);
    tick();
    check("s3_head_stable", 64'(pc0), 64'h44);

    // Scenario 2: six retires into a four-deep trace, then drain.
    do_clear();
    enable = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      mon.push = 1'b1;
      mon.push_data = {32'(4 * k), 32'h0000_1000 + 32'(k)};
      if (q0.size() < TD) q0.push_back(mon.push_data);
      q1.push_back(mon.push_data);
      if (q1.size() > TD) q1.pop_front();
      enable = (k != 5);
      tick();
    end
    mon.push = 1'b0;
    check("s2_level0", 64'(mon.level), 64'd4);
    check("s2_ovf0", 64'(mon.ovf), 64'd1);
    check("s2_level1", 64'(lvl1), 64'd4);
    check("s2_ovf1", 64'(ovf1), 64'd1);
    for (int i = 0; i < TD; i++) begin
      check($sformatf("s2_pop%0d_dut0", i), mon.head_data, q0.pop_front());
      check($sformatf("s2_pop%0d_dut1", i), {pc1, in1}, q1.pop_front());
      mon.pop = 1'b1;
      tick();
      mon.pop = 1'b0;
    end
    check("s2_empty0", 64'(mon.head_valid), 64'h0);
    check("s2_empty1", 64'(v1), 64'h0);
    check("s2_empty_lvl", 64'(mon.level), 64'h0);

    // Scenario 4: PC trigger freezes the monitor after the matching retire.
    do_clear();
    trig_en = 1'b1; trig_pc = 32'h18; enable = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      mon.push = 1'b1;
      mon.push_data = {32'h10 + 32'(4 * k), 32'h0000_0033};
      tick();
      if (k == 2) check("s4_frozen_at_hit", 64'(st0), 64'(ST_FROZEN));
    end
    mon.push = 1'b0;
    check("s4_frozen0", 64'(st0), 64'(ST_FROZEN));
    check("s4_frozen1", 64'(st1), 64'(ST_FROZEN));
    check("s4_level", 64'(mon.level), 64'd3);
    read_cnts(4);
    enable = 1'b0;
    tick();
    check("s4_idle", 64'(st0), 64'(ST_IDLE));
    trig_en = 1'b0;

    // Scenario 5: 300 stall cycles saturate an 8-bit counter.
    do_clear();
    enable = 1'b1;
    tick();
    for (int i = 0; i < 300; i++) begin
      stall  = 1'b1;
      enable = (i != 299);
      tick();
    end
    stall = 1'b0;
    read_cnts(5);

    // Scenario 6: asynchronous reset mid-trace.
    do_clear();
    enable = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      mon.push = 1'b1;
      mon.push_data = {32'h200 + 32'(4 * k), 32'h0000_0033};
      tick();
    end
    mon.push = 1'b0;
    sel = SEL_RETIRE;
    tick();
    check("s6_pre_level", 64'(mon.level), 64'd3);
    check("s6_pre_cnt", 64'(cnt0), 64'd3);
    #2;
    reset_n = 1'b0;
    #1;
    check("s6_state", 64'(st0), 64'(ST_IDLE));
    check("s6_cnt", 64'(cnt0), 64'h0);
    check("s6_valid", 64'(mon.head_valid), 64'h0);
    check("s6_head", mon.head_data, 64'h0);
    check("s6_level", 64'(mon.level), 64'h0);
    check("s6_ovf", 64'(mon.ovf), 64'h0);
    check("s6_valid1", 64'(v1), 64'h0);
    enable = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
